// File: rtl/sfr_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sfr_load_sequencer_if
// Description : Bundles the requester handshake (req/val/gnt/busy/done) and
//               the SFR control pins (sfr_clr/sfr_left/sfr_incr) that the
//               sfr_load_sequencer uses.
//               master : requester/integrator side (drives req/val)
//               slave  : sequencer side (drives gnt/busy/done/sfr_*)
// Revision    : 1.0  initial release
// ============================================================================
interface sfr_load_sequencer_if #(
    parameter int SIZE = 32
);
    logic            req0;
    logic [SIZE-1:0] val0;
    logic            req1;
    logic [SIZE-1:0] val1;
    logic            gnt0;
    logic            gnt1;
    logic            busy;
    logic            done;
    logic            sfr_clr;
    logic            sfr_left;
    logic            sfr_incr;

    modport master (
        output req0, val0, req1, val1,
        input  gnt0, gnt1, busy, done, sfr_clr, sfr_left, sfr_incr
    );

    modport slave (
        input  req0, val0, req1, val1,
        output gnt0, gnt1, busy, done, sfr_clr, sfr_left, sfr_incr
    );
endinterface
`default_nettype wire

// File: rtl/sfr_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sfr_load_sequencer
// Description : Loads an arbitrary SIZE-bit value into a shift/increment SFR
//               using only its clr/left/incr controls. Two requesters share
//               the SFR through a round-robin arbiter; a one-cycle done pulse
//               marks the point where the SFR holds the requested value.
// Ports       : clk        rising-edge clock
//               clr        synchronous active-high reset (aborts any load)
//               bus.slave  req0/val0, req1/val1 in; gnt0/gnt1/busy/done and
//                          sfr_clr/sfr_left/sfr_incr out (all Moore outputs)
// Options     : SFR_SEQ_SKIPZ_EN - when defined, leading zeros of the value
//               are skipped (RUN starts at the MSB '1'; zero goes CLR->DONE).
// Revision    : 1.0  initial release
// ============================================================================
module sfr_load_sequencer #(
    parameter int SIZE = 32,
    parameter int CW   = 6
) (
    input  logic                  clk,
    input  logic                  clr,
    sfr_load_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_STEP_LAST  = CW'(SIZE);
    localparam logic [CW-1:0] c_STEP_FIRST = CW'(1);

    state_t          r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_rr,    w_rr_nxt;      // 0: requester 0 wins a tie
    logic [SIZE-1:0] r_vreg,  w_vreg_nxt;
    logic [CW-1:0]   r_step,  w_step_nxt;

    logic            w_win;
    logic [CW-1:0]   w_bit_idx;
    logic            w_incr_bit;

    // Step j feeds vreg[SIZE-j]: MSB first, LSB on the final (unshifted) step.
    assign w_bit_idx = c_STEP_LAST - r_step;

    always_comb begin
        w_incr_bit = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (w_bit_idx == CW'(i)) begin
                w_incr_bit = r_vreg[i];
            end
        end
    end

`ifdef SFR_SEQ_SKIPZ_EN
    logic [CW-1:0] w_msb;
    logic          w_nz;

    // Priority encoder: index of the most significant '1' in vreg.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (r_vreg[i]) begin
                w_msb = CW'(i);
            end
        end
    end

    assign w_nz = |r_vreg;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_vreg  <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_vreg  <= w_vreg_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_vreg_nxt  = r_vreg;
        w_step_nxt  = r_step;
        w_win       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Tie goes to the rr pointer; otherwise the sole requester.
                    if (bus.req0 && bus.req1) begin
                        w_win = r_rr;
                    end else begin
                        w_win = bus.req1;
                    end
                    w_owner_nxt = w_win;
                    w_rr_nxt    = ~w_win;
                    w_vreg_nxt  = w_win ? bus.val1 : bus.val0;
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
`ifdef SFR_SEQ_SKIPZ_EN
                // Shifting a cleared SFR is a no-op, so leading zeros cost nothing.
                if (!w_nz) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_step_nxt  = c_STEP_LAST - w_msb;
                    w_state_nxt = S_RUN;
                end
`else
                w_step_nxt  = c_STEP_FIRST;
                w_state_nxt = S_RUN;
`endif
            end
            S_RUN: begin
                if (r_step == c_STEP_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_step_nxt = r_step + c_STEP_FIRST;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.gnt0     = bus.busy && !r_owner;
    assign bus.gnt1     = bus.busy &&  r_owner;
    assign bus.done     = (r_state == S_DONE);
    assign bus.sfr_clr  = (r_state == S_CLR);
    // The final step only adds the LSB; every earlier step also shifts.
    assign bus.sfr_left = (r_state == S_RUN) && (r_step != c_STEP_LAST);
    assign bus.sfr_incr = (r_state == S_RUN) && w_incr_bit;

endmodule
`default_nettype wire

// File: tb/tb_sfr_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfr_load_sequencer
// Description : Directed self-checking bench for sfr_load_sequencer (SIZE=8)
//               with a behavioural model of the target shift/increment SFR.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sfr_load_sequencer;

    localparam int SIZE = 8;
    localparam int CW   = 4;

`ifdef SFR_SEQ_SKIPZ_EN
    localparam int B_3C = 8;
    localparam int B_00 = 2;
    localparam int L_00 = 0;
    localparam int B_05 = 5;
    localparam int L_05 = 2;
`else
    localparam int B_3C = 10;
    localparam int B_00 = 10;
    localparam int L_00 = 7;
    localparam int B_05 = 10;
    localparam int L_05 = 7;
`endif

    logic clk;
    logic clr;
    logic [SIZE-1:0] sfr_q;

    int checks   = 0;
    int failures = 0;

    // results of the most recent observe_load
    int              o_own;
    int              o_bcyc;
    int              o_lcyc;
    int              o_wait;
    logic [SIZE-1:0] o_q;
    bit              o_clr1;
    bit              o_bad;
    bit              o_tmo;

    sfr_load_sequencer_if #(.SIZE(SIZE)) bus ();

    sfr_load_sequencer #(.SIZE(SIZE), .CW(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target SFR model; its clr is the system clr ORed with sfr_clr.
    always @(posedge clk) begin
        if (clr || bus.sfr_clr)                  sfr_q <= '0;
        else if (bus.sfr_left && bus.sfr_incr)   sfr_q <= (sfr_q + 8'd1) << 1;
        else if (bus.sfr_incr)                   sfr_q <= sfr_q + 8'd1;
        else if (bus.sfr_left)                   sfr_q <= sfr_q << 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows one load from the current cycle until done, recording what it
    // saw. Optionally drops the owner's request in the done cycle.
    task automatic observe_load(input bit drop);
        bit found;
        bit started;
        found   = 1'b0;
        started = 1'b0;
        o_own   = -1;
        o_bcyc  = 0;
        o_lcyc  = 0;
        o_wait  = 0;
        o_q     = 'x;
        o_clr1  = 1'b0;
        o_bad   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.busy) begin
                if (!started) begin
                    started = 1'b1;
                    o_clr1  = bus.sfr_clr;
                    o_own   = bus.gnt1 ? 1 : 0;
                end
                o_bcyc++;
                if (bus.sfr_left) o_lcyc++;
                if ((bus.gnt0 && bus.gnt1) || (!bus.gnt0 && !bus.gnt1) ||
                    (o_own == 1 && !bus.gnt1) || (o_own == 0 && !bus.gnt0))
                    o_bad = 1'b1;
            end else begin
                if (!started) o_wait++;
                else          o_bad = 1'b1;
            end
            if (bus.done) begin
                o_q   = sfr_q;
                found = 1'b1;
                if (drop) begin
                    if (o_own == 1) bus.req1 = 1'b0;
                    else            bus.req0 = 1'b0;
                end
                break;
            end
            tick();
        end
        o_tmo = !found;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.val0 = '0;
        bus.val1 = '0;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.val0 = 8'hFF;
        bus.val1 = 8'hFF;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_gnt got=%b%b exp=00", bus.gnt0, bus.gnt1);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        checks++;
        if ({bus.sfr_clr, bus.sfr_left, bus.sfr_incr} !== 3'b000) begin
            failures++;
            $display("FAIL reset_sfr_ctl got=%b%b%b exp=000", bus.sfr_clr, bus.sfr_left, bus.sfr_incr);
        end
        do_reset();
    endtask

    task automatic test_single();
        bus.req0 = 1'b1;
        bus.val0 = 8'hA5;
        observe_load(1'b1);
        checks++;
        if (o_tmo !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", o_tmo); end
        checks++;
        if (o_own !== 0) begin failures++; $display("FAIL single_owner got=%0d exp=0", o_own); end
        checks++;
        if (o_wait !== 1) begin failures++; $display("FAIL single_grant_latency got=%0d exp=1", o_wait); end
        checks++;
        if (o_clr1 !== 1'b1) begin failures++; $display("FAIL single_first_clr got=%b exp=1", o_clr1); end
        checks++;
        if (o_bcyc !== 10) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=10", o_bcyc); end
        checks++;
        if (o_lcyc !== 7) begin failures++; $display("FAIL single_left_cycles got=%0d exp=7", o_lcyc); end
        checks++;
        if (o_q !== 8'hA5) begin failures++; $display("FAIL single_q got=%h exp=a5", o_q); end
        checks++;
        if (o_bad !== 1'b0) begin failures++; $display("FAIL single_gnt_consistency got=%b exp=0", o_bad); end
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL single_after_done got=%b%b exp=00", bus.busy, bus.done);
        end
    endtask

    task automatic test_contend();
        do_reset();
        bus.req0 = 1'b1;
        bus.val0 = 8'h3C;
        bus.req1 = 1'b1;
        bus.val1 = 8'hC3;
        observe_load(1'b1);
        checks++;
        if (o_own !== 0 || o_tmo) begin failures++; $display("FAIL contend_first_owner got=%0d exp=0", o_own); end
        checks++;
        if (o_q !== 8'h3C) begin failures++; $display("FAIL contend_first_q got=%h exp=3c", o_q); end
        checks++;
        if (o_bcyc !== B_3C) begin failures++; $display("FAIL contend_first_busy got=%0d exp=%0d", o_bcyc, B_3C); end
        tick();
        observe_load(1'b1);
        checks++;
        if (o_own !== 1 || o_tmo) begin failures++; $display("FAIL contend_second_owner got=%0d exp=1", o_own); end
        checks++;
        if (o_q !== 8'hC3) begin failures++; $display("FAIL contend_second_q got=%h exp=c3", o_q); end
        checks++;
        if (o_wait !== 1) begin failures++; $display("FAIL contend_second_wait got=%0d exp=1", o_wait); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [SIZE-1:0] exp_q;
        bus.req0 = 1'b1;
        bus.val0 = 8'h5A;
        bus.req1 = 1'b1;
        bus.val1 = 8'h96;
        for (int i = 0; i < 4; i++) begin
            exp_q = (i % 2 == 1) ? 8'h96 : 8'h5A;
            observe_load(1'b0);
            checks++;
            if (o_own !== (i % 2) || o_tmo) begin
                failures++;
                $display("FAIL b2b_owner[%0d] got=%0d exp=%0d", i, o_own, i % 2);
            end
            checks++;
            if (o_q !== exp_q) begin
                failures++;
                $display("FAIL b2b_q[%0d] got=%h exp=%h", i, o_q, exp_q);
            end
            checks++;
            if (o_bad !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gnt[%0d] got=%b exp=0", i, o_bad);
            end
            tick();
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                failures++;
                $display("FAIL b2b_idle_gap[%0d] got=%b%b exp=00", i, bus.busy, bus.done);
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_values();
        do_reset();
        bus.req0 = 1'b1;
        bus.val0 = 8'hFF;
        observe_load(1'b1);
        checks++;
        if (o_q !== 8'hFF || o_tmo) begin failures++; $display("FAIL val_ff_q got=%h exp=ff", o_q); end
        checks++;
        if (o_bcyc !== 10) begin failures++; $display("FAIL val_ff_busy got=%0d exp=10", o_bcyc); end
        tick();
        bus.req0 = 1'b1;
        bus.val0 = 8'h00;
        observe_load(1'b1);
        checks++;
        if (o_q !== 8'h00 || o_tmo) begin failures++; $display("FAIL val_00_q got=%h exp=00", o_q); end
        checks++;
        if (o_bcyc !== B_00) begin failures++; $display("FAIL val_00_busy got=%0d exp=%0d", o_bcyc, B_00); end
        checks++;
        if (o_lcyc !== L_00) begin failures++; $display("FAIL val_00_left got=%0d exp=%0d", o_lcyc, L_00); end
        tick();
        bus.req0 = 1'b1;
        bus.val0 = 8'h05;
        observe_load(1'b1);
        checks++;
        if (o_q !== 8'h05 || o_tmo) begin failures++; $display("FAIL val_05_q got=%h exp=05", o_q); end
        checks++;
        if (o_bcyc !== B_05) begin failures++; $display("FAIL val_05_busy got=%0d exp=%0d", o_bcyc, B_05); end
        checks++;
        if (o_lcyc !== L_05) begin failures++; $display("FAIL val_05_left got=%0d exp=%0d", o_lcyc, L_05); end
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        bus.req0 = 1'b1;
        bus.val0 = 8'hA5;
        tick();                       // CLR
        for (int i = 0; i < 4; i++) tick();   // RUN step 4
        checks++;
        if ({bus.busy, bus.gnt0} !== 2'b11) begin
            failures++;
            $display("FAIL abort_pre_state got=%b%b exp=11", bus.busy, bus.gnt0);
        end
        clr = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.val1 = 8'h69;
        tick();
        checks++;
        if ({bus.busy, bus.gnt0, bus.gnt1, bus.done, bus.sfr_clr, bus.sfr_left, bus.sfr_incr} !== 7'b0) begin
            failures++;
            $display("FAIL abort_outputs got=%b%b%b%b%b%b%b exp=0000000", bus.busy, bus.gnt0, bus.gnt1,
                     bus.done, bus.sfr_clr, bus.sfr_left, bus.sfr_incr);
        end
        clr = 1'b0;
        observe_load(1'b1);
        checks++;
        if (o_own !== 1 || o_tmo) begin failures++; $display("FAIL abort_pending_owner got=%0d exp=1", o_own); end
        checks++;
        if (o_q !== 8'h69) begin failures++; $display("FAIL abort_pending_q got=%h exp=69", o_q); end
        checks++;
        if (o_wait !== 1) begin failures++; $display("FAIL abort_pending_wait got=%0d exp=1", o_wait); end
        tick();
        // Grant requester 0 (pointer moves to 1), abort, then contend: the
        // reset pointer must favour requester 0 again.
        bus.req0 = 1'b1;
        bus.val0 = 8'h11;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.req1 = 1'b1;
        bus.val1 = 8'h22;
        observe_load(1'b1);
        checks++;
        if (o_own !== 0 || o_tmo) begin failures++; $display("FAIL abort_rr_reset_owner got=%0d exp=0", o_own); end
        checks++;
        if (o_q !== 8'h11) begin failures++; $display("FAIL abort_rr_reset_q got=%h exp=11", o_q); end
        tick();
        observe_load(1'b1);
        checks++;
        if (o_own !== 1 || o_q !== 8'h22 || o_tmo) begin
            failures++;
            $display("FAIL abort_rr_second got owner=%0d q=%h exp owner=1 q=22", o_own, o_q);
        end
        tick();
    endtask

    task automatic test_val_change();
        do_reset();
        bus.req0 = 1'b1;
        bus.val0 = 8'h81;
        tick();      // CLR
        tick();      // RUN 1
        tick();      // RUN 2
        bus.val0 = 8'h7E;
        bus.req1 = 1'b1;
        bus.val1 = 8'h24;
        observe_load(1'b1);
        checks++;
        if (o_own !== 0 || o_tmo) begin failures++; $display("FAIL valchg_owner got=%0d exp=0", o_own); end
        checks++;
        if (o_q !== 8'h81) begin failures++; $display("FAIL valchg_q got=%h exp=81", o_q); end
        checks++;
        if (o_bad !== 1'b0) begin failures++; $display("FAIL valchg_nonowner_gnt got=%b exp=0", o_bad); end
        tick();
        observe_load(1'b1);
        checks++;
        if (o_own !== 1 || o_q !== 8'h24 || o_tmo) begin
            failures++;
            $display("FAIL valchg_second got owner=%0d q=%h exp owner=1 q=24", o_own, o_q);
        end
        tick();
    endtask

    initial begin
        clr      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.val0 = '0;
        bus.val1 = '0;
        test_reset();
        test_single();
        test_contend();
        test_back_to_back();
        test_values();
        test_abort();
        test_val_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
